lcd_text_display: RTL

- Parametrised character-LCD driver for HD44780-compatible panels. Successor to the fixed 400 Hz, 16x2 LCD top.
- Owns a ROWS x COLS character buffer written by the application over a simple write port.
- Runs power-up init, then refreshes the panel from the buffer, either continuously or only when the buffer changed.
- Contains its own clock-enable divider; drives the LCD pins directly.

---
 rtl/lcd_text_display.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_text_display.sv
// HD44780 character-LCD driver: power-up init, then frame refresh from an
// internal ROWS x COLS character buffer, paced by an internal tick divider.
module lcd_text_display #(
  parameter int DIV           = 125000,
  parameter int POWERUP_TICKS = 8,
  parameter int ROWS          = 2,
  parameter int COLS          = 16,
  parameter int REFRESH_MODE  = 0,
  localparam int NCHAR        = ROWS * COLS,
  localparam int AW           = (NCHAR > 1) ? $clog2(NCHAR) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          init_done,
  output logic          frame_done,
  output logic          busy,
  output logic          LCD_ON,
  output logic          LCD_RS,
  output logic          LCD_EN,
  output logic          LCD_RW,
  output logic [7:0]    LCD_DATA
);

  localparam int CW   = $clog2(DIV);
  localparam int PW   = (POWERUP_TICKS > 1) ? $clog2(POWERUP_TICKS) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COLW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [2:0] S_PWR  = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_CHAR = 3'd3;
  localparam logic [2:0] S_IDLE = 3'd4;

  logic [CW-1:0]   cnt_reg;
  logic            tick;
  logic [2:0]      state_reg;
  logic            phase_reg;
  logic [PW-1:0]   pwr_cnt_reg;
  logic [1:0]      init_idx_reg;
  logic [RW-1:0]   row_reg;
  logic [COLW-1:0] col_reg;
  logic            rs_reg;
  logic            en_reg;
  logic [7:0]      data_reg;
  logic            lcd_on_reg;
  logic            init_done_reg;
  logic            frame_done_reg;
  logic            dirty_reg;
  logic            wr_ok;
  logic            last_row;
  logic            last_col;
  logic            start_frame;
  logic [7:0]      init_cmd;
  logic [7:0]      addr_cmd;
  logic [AW-1:0]   char_idx;
  logic [7:0]      cur_char;
  logic [7:0]      char_mem [NCHAR];

  assign tick = (cnt_reg == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt_reg <= '0;
    else if (tick) cnt_reg <= '0;
    else           cnt_reg <= cnt_reg + CW'(1);
  end

  // Registers rather than RAM: every byte must return to a space on reset.
  assign wr_ok = wr_en && (32'(wr_addr) < 32'(NCHAR));

  genvar gi;
  generate
    for (gi = 0; gi < NCHAR; gi++) begin : g_char
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          char_mem[gi] <= 8'h20;
        else if (wr_en && (wr_addr == AW'(gi)))
          char_mem[gi] <= wr_data;
      end
    end
  endgenerate

  assign last_row = (row_reg == RW'(ROWS - 1));
  assign last_col = (col_reg == COLW'(COLS - 1));
  assign char_idx = AW'(int'(row_reg) * COLS + int'(col_reg));
  assign cur_char = char_mem[char_idx];
  assign addr_cmd = 8'h80 | 8'((int'(row_reg) % 2) * 64 + (int'(row_reg) / 2) * COLS);

  always_comb begin
    init_cmd = 8'h38;
    case (init_idx_reg)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  end

  // Every transition into S_ADDR row 0 starts a frame and consumes the dirty flag.
  assign start_frame = tick && (
      (state_reg == S_INIT && phase_reg && init_idx_reg == 2'd3) ||
      (state_reg == S_CHAR && phase_reg && last_col && last_row &&
       (REFRESH_MODE == 0 || dirty_reg)) ||
      (state_reg == S_IDLE && dirty_reg));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            dirty_reg <= 1'b1;
    else if (wr_ok)       dirty_reg <= 1'b1;
    else if (start_frame) dirty_reg <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_PWR;
      phase_reg      <= 1'b0;
      pwr_cnt_reg    <= '0;
      init_idx_reg   <= 2'd0;
      row_reg        <= '0;
      col_reg        <= '0;
      rs_reg         <= 1'b0;
      en_reg         <= 1'b0;
      data_reg       <= 8'h00;
      lcd_on_reg     <= 1'b0;
      init_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      lcd_on_reg     <= 1'b1;
      frame_done_reg <= 1'b0;
      if (tick) begin
        case (state_reg)
          S_PWR: begin
            if (pwr_cnt_reg == PW'(POWERUP_TICKS - 1)) state_reg <= S_INIT;
            else pwr_cnt_reg <= pwr_cnt_reg + PW'(1);
          end
          S_INIT: begin
            if (!phase_reg) begin
              rs_reg    <= 1'b0;
              data_reg  <= init_cmd;
              en_reg    <= 1'b1;
              phase_reg <= 1'b1;
            end else begin
              en_reg    <= 1'b0;
              phase_reg <= 1'b0;
              if (init_idx_reg == 2'd3) begin
                init_done_reg <= 1'b1;
                state_reg     <= S_ADDR;
                row_reg       <= '0;
              end else begin
                init_idx_reg <= init_idx_reg + 2'd1;
              end
            end
          end
          S_ADDR: begin
            if (!phase_reg) begin
              rs_reg    <= 1'b0;
              data_reg  <= addr_cmd;
              en_reg    <= 1'b1;
              phase_reg <= 1'b1;
            end else begin
              en_reg    <= 1'b0;
              phase_reg <= 1'b0;
              state_reg <= S_CHAR;
              col_reg   <= '0;
            end
          end
          S_CHAR: begin
            if (!phase_reg) begin
              rs_reg    <= 1'b1;
              data_reg  <= cur_char;
              en_reg    <= 1'b1;
              phase_reg <= 1'b1;
            end else begin
              en_reg    <= 1'b0;
              phase_reg <= 1'b0;
              if (!last_col) begin
                col_reg <= col_reg + COLW'(1);
              end else if (!last_row) begin
                col_reg   <= '0;
                row_reg   <= row_reg + RW'(1);
                state_reg <= S_ADDR;
              end else begin
                col_reg        <= '0;
                row_reg        <= '0;
                frame_done_reg <= 1'b1;
                state_reg      <= start_frame ? S_ADDR : S_IDLE;
              end
            end
          end
          S_IDLE: begin
            en_reg <= 1'b0;
            if (dirty_reg) begin
              state_reg <= S_ADDR;
              row_reg   <= '0;
            end
          end
          default: state_reg <= S_PWR;
        endcase
      end
    end
  end

  assign init_done  = init_done_reg;
  assign frame_done = frame_done_reg;
  assign busy       = (state_reg != S_IDLE);
  assign LCD_ON     = lcd_on_reg;
  assign LCD_RS     = rs_reg;
  assign LCD_EN     = en_reg;
  assign LCD_RW     = 1'b0;
  assign LCD_DATA   = data_reg;

endmodule
